mmio_timer_bank: RTL and testbench

//  Parametrised multi-channel programmable timer / interrupt source on the CPU's MMIO bridge.

---
 rtl/timer_pkg.sv | 31 +++
 rtl/timer_channel.sv | 118 +++++++++++
 rtl/mmio_timer_bank.sv | 70 +++++++
 tb/tb_mmio_timer_bank.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the MMIO timer bank: register map, CTRL fields, modes, channel states.
package timer_pkg;

    // Register offsets within a channel's 16-byte slot, as word index addr[3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE encodings; any value other than MODE_RELOAD behaves as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT,
        ST_INT
    } ch_state_e;

    function automatic logic mode_is_reload(input logic [1:0] mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL/PRESET/COUNT/PEND registers, the channel FSM and the irq flop.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_ctrl,
    input  logic          we_preset,
    input  logic          we_status,
    input  logic [31:0]   wdata,
    output logic [31:0]   ctrl_rd,
    output logic [CW-1:0] preset,
    output logic [CW-1:0] count,
    output logic          pend,
    output logic          irq
);

    ch_state_e     state_q, state_d;
    logic          en_q, en_d;
    logic [1:0]    mode_q, mode_d;
    logic          im_q, im_d;
    logic [CW-1:0] preset_q, preset_d;
    logic [CW-1:0] count_q, count_d;
    logic          pend_q, pend_d;
    logic          irq_q, irq_d;
    logic          en_go;
    logic          pend_set;
    logic          unused_wdata;

    // Upper write-data bits beyond the implemented fields are don't-care
    assign unused_wdata = ^wdata;

    // Next-state logic: FSM first, then bus writes so a CTRL write overrides INT's EN clear
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_set = 1'b0;
        // A CTRL write this cycle takes effect immediately for start/stop decisions
        en_go    = we_ctrl ? wdata[CTRL_EN] : en_q;

        case (state_q)
            ST_IDLE: begin
                if (en_go) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!en_go) begin
                    state_d = ST_IDLE;
                end else if (count_q <= CW'(1)) begin
                    count_d  = '0;
                    pend_set = 1'b1;
                    state_d  = ST_INT;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            ST_INT: begin
                if (mode_is_reload(mode_q)) begin
                    state_d = ST_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (we_ctrl) begin
            en_d   = wdata[CTRL_EN];
            mode_d = wdata[CTRL_MODE_HI:CTRL_MODE_LO];
            im_d   = wdata[CTRL_IM];
        end
        if (we_preset) preset_d = wdata[CW-1:0];

        // Hardware set beats a simultaneous write-1-to-clear
        pend_d = pend_set | (pend_q & ~(we_status & wdata[0]));
        irq_d  = pend_q & im_q;
    end

    // Register update with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            en_q     <= 1'b0;
            mode_q   <= MODE_ONESHOT;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
        end
    end

    assign ctrl_rd = {28'b0, im_q, mode_q, en_q};
    assign preset  = preset_q;
    assign count   = count_q;
    assign pend    = pend_q;
    assign irq     = irq_q;

endmodule

// File: rtl/mmio_timer_bank.sv
// Multi-channel programmable timer bank: address decode, channel array, read mux, irq OR.
module mmio_timer_bank
    import timer_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int CW     = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [N_CH-1:0]   irq,
    output logic              irq_any
);

    localparam int CH_W = ADDR_W - 4;

    logic [CH_W-1:0] ch_sel;
    logic [1:0]      reg_sel;
    logic [31:0]     ctrl_rd   [N_CH];
    logic [CW-1:0]   preset_rd [N_CH];
    logic [CW-1:0]   count_rd  [N_CH];
    logic [N_CH-1:0] pend_rd;
    logic            unused_addr;

    assign ch_sel      = addr[ADDR_W-1:4];
    assign reg_sel     = addr[3:2];
    assign unused_addr = ^addr[1:0];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic hit;
        assign hit = we && (ch_sel == CH_W'(i));

        timer_channel #(.CW(CW)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .we_ctrl   (hit && reg_sel == REG_CTRL),
            .we_preset (hit && reg_sel == REG_PRESET),
            .we_status (hit && reg_sel == REG_STATUS),
            .wdata     (wdata),
            .ctrl_rd   (ctrl_rd[i]),
            .preset    (preset_rd[i]),
            .count     (count_rd[i]),
            .pend      (pend_rd[i]),
            .irq       (irq[i])
        );
    end

    // Read mux; unpopulated channel slots read as zero
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (reg_sel)
                    REG_CTRL:   rdata = ctrl_rd[i];
                    REG_PRESET: rdata = 32'(preset_rd[i]);
                    REG_COUNT:  rdata = 32'(count_rd[i]);
                    REG_STATUS: rdata = 32'(pend_rd[i]);
                    default:    rdata = '0;
                endcase
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_mmio_timer_bank.sv
// Self-checking bench for mmio_timer_bank (4 channels, 8-bit counters).
module tb_mmio_timer_bank;

    localparam int N_CH   = 4;
    localparam int CW     = 8;
    localparam int ADDR_W = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic [N_CH-1:0]   irq;
    logic              irq_any;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          rise_q[$];

    always #5 clk = ~clk;

    mmio_timer_bank #(.N_CH(N_CH), .CW(CW), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .wdata   (wdata),
        .rdata   (rdata),
        .irq     (irq),
        .irq_any (irq_any)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        addr = a;
        #1;
        check(tag_q.pop_front(), rdata, exp_q.pop_front());
    endtask

    task automatic chk_irq(input string tag, input logic [N_CH-1:0] e);
        check(tag, 32'(irq), 32'(e));
        check({tag, "_any"}, 32'(irq_any), 32'(|e));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rise;
        logic [N_CH-1:0] e_irq;

        reset = 1'b1; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) tick();
        reset = 1'b0;
        rd(7'h00, 32'h0, "init_ctrl0");
        chk_irq("init_irq", '0);

        // Reset held three cycles while ch0 counts
        wr(7'h04, 20);
        wr(7'h00, 32'h9);
        repeat (3) tick();
        rd(7'h08, 18, "t1_count_before_rst");
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        rd(7'h00, 0, "t1_ctrl");
        rd(7'h04, 0, "t1_preset");
        rd(7'h08, 0, "t1_count");
        rd(7'h0C, 0, "t1_pend");
        chk_irq("t1_irq", '0);
        tick();
        rd(7'h08, 0, "t1_idle_count");
        rd(7'h00, 0, "t1_idle_ctrl");

        // One-shot on ch0, PRESET=5
        wr(7'h04, 5);
        wr(7'h00, 32'h9);
        for (int j = 1; j <= 5; j++) begin
            tick();
            rd(7'h08, 32'(6 - j), "t2_count");
            rd(7'h0C, 0, "t2_pend_low");
        end
        tick();
        rd(7'h0C, 1, "t2_pend");
        chk_irq("t2_irq_early", '0);
        tick();
        chk_irq("t2_irq", 4'b0001);
        rd(7'h00, 32'h8, "t2_ctrl_en_clr");
        rd(7'h08, 0, "t2_count_zero");

        // Auto-reload on ch1, PRESET=3: PEND every 5 cycles, cleared by W1C
        wr(7'h14, 3);
        wr(7'h10, 32'hB);
        rise_q.push_back(4);
        rise_q.push_back(9);
        rise_q.push_back(14);
        n_rise = 0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            we   = 1'b0;
            addr = 7'h1C;
            #1;
            if (t == 5) check("t3_irq1_hold", 32'(irq[1]), 1);
            if (t == 6) check("t3_irq1_drop", 32'(irq[1]), 0);
            if (rdata[0]) begin
                n_rise++;
                if (rise_q.size() == 0) check("t3_extra_rise", t, 0);
                else check("t3_rise_cycle", t, rise_q.pop_front());
                wdata = 1;
                we    = 1'b1;
            end
        end
        tick();
        we = 1'b0;
        check("t3_rise_count", n_rise, 3);
        check("t3_ch0_irq_unaffected", 32'(irq[0]), 1);
        rd(7'h0C, 1, "t3_ch0_pend");
        wr(7'h10, 0);
        wr(7'h1C, 1);
        wr(7'h0C, 1);
        tick();
        chk_irq("t3_all_clear", '0);

        // Disable mid-count on ch2 freezes COUNT; re-enable reloads
        wr(7'h24, 20);
        wr(7'h20, 32'h1);
        repeat (14) tick();
        rd(7'h28, 7, "t4_count7");
        wr(7'h20, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            rd(7'h28, 7, "t4_hold");
        end
        wr(7'h24, 9);
        wr(7'h20, 32'h1);
        tick();
        rd(7'h28, 9, "t4_reload");
        wr(7'h24, 30);
        rd(7'h28, 8, "t4_preset_deferred");
        rd(7'h24, 30, "t4_preset_rb");
        wr(7'h20, 0);

        // ch3: W1C on the set edge, IM=0, CTRL write over INT's EN clear
        wr(7'h34, 2);
        wr(7'h30, 32'h1);
        tick();
        tick();
        wr(7'h3C, 1);
        rd(7'h3C, 1, "t5_pend_set_wins");
        wr(7'h30, 32'h1);
        rd(7'h30, 1, "t5_ctrl_write_wins");
        rd(7'h3C, 1, "t5_pend_held");
        chk_irq("t5_im0", '0);
        wr(7'h30, 0);
        wr(7'h3C, 1);
        rd(7'h3C, 0, "t5_pend_clr");

        // Width truncation, out-of-range slot, read-only COUNT
        wr(7'h04, 32'h1FF);
        rd(7'h04, 32'hFF, "t6_preset_trunc");
        wr(7'h14, 32'hFF);
        wr(7'h24, 32'hFF);
        wr(7'h34, 32'hFF);
        wr(7'h40, 32'hF);
        wr(7'h44, 32'h55);
        rd(7'h40, 0, "t6_oor_ctrl");
        rd(7'h44, 0, "t6_oor_preset");
        rd(7'h7C, 0, "t6_oor_status");
        rd(7'h00, 32'h8, "t6_ch0_ctrl_intact");
        wr(7'h08, 32'h55);
        rd(7'h08, 0, "t6_count_ro");

        // All four channels, staggered starts, PRESET=0xFF
        wr(7'h00, 32'h9);
        wr(7'h10, 32'h9);
        wr(7'h20, 32'h9);
        wr(7'h30, 32'h9);
        for (int t = 1; t <= 260; t++) begin
            tick();
            if (t >= 250) begin
                for (int i = 0; i < N_CH; i++) e_irq[i] = (t >= i + 254);
                chk_irq("t6_irq", e_irq);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
